// File: rtl/core_pkg.sv
// Shared definitions for the memory arbiter: arbitration mode encodings
// and the helper that locates one port's field inside a packed bus.
package core_pkg;

    // Arbitration policy selected by the PRIO_MODE parameter.
    typedef enum logic [0:0] {
        PRIO_RR    = 1'b0,  // round-robin, search starts at the pointer
        PRIO_FIXED = 1'b1   // fixed priority, port 0 highest
    } prio_mode_e;

    // Lowest bit of port idx's field in a bus packed as {port N-1, ..., port 0}.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way arbiter: request vector in, one-hot grant out. In round-robin mode
// it keeps its own pointer that advances past the last winner; in fixed
// priority mode the lowest-indexed requester always wins.
module rr_arbiter
    import core_pkg::*;
#(
    parameter int N_PORTS   = 2,
    parameter int PRIO_MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] i_req,
    output logic [N_PORTS-1:0] o_gnt
);

    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [PTR_W-1:0]   r_ptr;
    logic [N_PORTS-1:0] w_req;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic               w_any;
    int                 w_scan;

    // Nothing is granted while reset is held, whatever the requesters do.
    assign w_req = rst ? '0 : i_req;

    // Pick the winner for this cycle and the pointer that follows it.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves a value unassigned, which would infer a latch.
        o_gnt     = '0;
        w_gnt_idx = '0;
        w_any     = 1'b0;
        w_scan    = 0;
        if (PRIO_MODE == int'(PRIO_FIXED)) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (!w_any && w_req[i]) begin
                    w_any     = 1'b1;
                    w_gnt_idx = PTR_W'(i);
                end
            end
        end else begin
            for (int off = 0; off < N_PORTS; off++) begin
                w_scan = int'(r_ptr) + off;
                if (w_scan >= N_PORTS) begin
                    w_scan = w_scan - N_PORTS;
                end
                if (!w_any && w_req[w_scan]) begin
                    w_any     = 1'b1;
                    w_gnt_idx = PTR_W'(w_scan);
                end
            end
        end
        if (w_any) begin
            o_gnt[w_gnt_idx] = 1'b1;
        end
        w_ptr_nxt = (w_gnt_idx == PTR_W'(N_PORTS - 1)) ? '0 : w_gnt_idx + 1'b1;
    end

    // Advance the pointer one past the winner; an idle cycle leaves it alone.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge value of its inputs.
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any && PRIO_MODE != int'(PRIO_FIXED)) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates N requester ports onto a single memory port. Read and write
// channels each have their own arbiter, so one read and one write can issue
// in the same cycle. Grants are combinational; the winning request drives
// the memory side in the same cycle. Read returns are routed back through
// an RD_LAT-deep pipeline carrying the one-hot index of the issuing port.
module mem_arbiter
    import core_pkg::*;
#(
    parameter int N_PORTS   = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int PRIO_MODE = 0
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [N_PORTS-1:0]          p_r_en,
    input  logic [N_PORTS*ADDR_W-1:0]   p_r_addr,
    output logic [N_PORTS-1:0]          p_r_gnt,
    output logic [N_PORTS-1:0]          p_r_valid,
    output logic [DATA_W-1:0]           p_r_data,

    input  logic [N_PORTS-1:0]          p_w_en,
    input  logic [N_PORTS*ADDR_W-1:0]   p_w_addr,
    input  logic [N_PORTS*DATA_W-1:0]   p_w_data,
    output logic [N_PORTS-1:0]          p_w_gnt,

    output logic                        m_r_en,
    output logic [ADDR_W-1:0]           m_r_addr,
    output logic                        m_w_en,
    output logic [ADDR_W-1:0]           m_w_addr,
    output logic [DATA_W-1:0]           m_w_data,
    input  logic [DATA_W-1:0]           m_r_data
);

    logic [N_PORTS-1:0] w_r_gnt;
    logic [N_PORTS-1:0] w_w_gnt;
    logic [N_PORTS-1:0] r_rd_pipe [RD_LAT];

    rr_arbiter #(
        .N_PORTS   (N_PORTS),
        .PRIO_MODE (PRIO_MODE)
    ) u_rd_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (p_r_en),
        .o_gnt (w_r_gnt)
    );

    rr_arbiter #(
        .N_PORTS   (N_PORTS),
        .PRIO_MODE (PRIO_MODE)
    ) u_wr_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (p_w_en),
        .o_gnt (w_w_gnt)
    );

    assign p_r_gnt = w_r_gnt;
    assign p_w_gnt = w_w_gnt;
    assign m_r_en  = |w_r_gnt;
    assign m_w_en  = |w_w_gnt;

    // Steer the granted port's address and data onto the memory side.
    always_comb begin
        m_r_addr = '0;
        m_w_addr = '0;
        m_w_data = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (w_r_gnt[i]) begin
                m_r_addr = p_r_addr[slice_lo(i, ADDR_W) +: ADDR_W];
            end
            if (w_w_gnt[i]) begin
                m_w_addr = p_w_addr[slice_lo(i, ADDR_W) +: ADDR_W];
                m_w_data = p_w_data[slice_lo(i, DATA_W) +: DATA_W];
            end
        end
    end

    // Carry each read grant down the pipeline so it surfaces with its data.
    always_ff @(posedge clk) begin
        // NOTE: this pipeline is reset, unlike a data-only array, because a
        // stale entry would fire a p_r_valid for a read that reset cancelled.
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_rd_pipe[k] <= '0;
            end
        end else begin
            r_rd_pipe[0] <= w_r_gnt;
            for (int k = 1; k < RD_LAT; k++) begin
                r_rd_pipe[k] <= r_rd_pipe[k-1];
            end
        end
    end

    assign p_r_valid = rst ? '0 : r_rd_pipe[RD_LAT-1];
    assign p_r_data  = m_r_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter. Two instances: A is 4-port round-robin
// with RD_LAT=3, B is 3-port fixed priority with RD_LAT=2. Each stimulus
// vector pushes its expected grants/memory-side values and, for reads, the
// expected return (port, data, due cycle); monitors on the falling edge pop
// and compare.
module tb_mem_arbiter;

    typedef struct {
        logic [3:0]  r_gnt;
        logic [3:0]  w_gnt;
        logic [31:0] r_addr;
        logic [31:0] w_addr;
        logic [31:0] w_data;
    } gexp_t;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] data;
        int          due;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    gexp_t a_gq[$];
    gexp_t b_gq[$];
    rexp_t a_rq[$];
    rexp_t b_rq[$];
    gexp_t a_ge, b_ge;
    rexp_t a_re, b_re;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- instance A: 4 ports, RD_LAT=3, round-robin
    logic [3:0]   a_r_en, a_w_en, a_r_gnt, a_w_gnt, a_p_r_valid;
    logic [127:0] a_r_addr, a_w_addr, a_w_data;
    logic [31:0]  a_p_r_data, a_m_r_addr, a_m_w_addr, a_m_w_data, a_m_r_data;
    logic         a_m_r_en, a_m_w_en;
    logic [31:0]  a_mp [3];

    mem_arbiter #(
        .N_PORTS(4), .ADDR_W(32), .DATA_W(32), .RD_LAT(3), .PRIO_MODE(0)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .p_r_en(a_r_en), .p_r_addr(a_r_addr), .p_r_gnt(a_r_gnt),
        .p_r_valid(a_p_r_valid), .p_r_data(a_p_r_data),
        .p_w_en(a_w_en), .p_w_addr(a_w_addr), .p_w_data(a_w_data), .p_w_gnt(a_w_gnt),
        .m_r_en(a_m_r_en), .m_r_addr(a_m_r_addr), .m_w_en(a_m_w_en),
        .m_w_addr(a_m_w_addr), .m_w_data(a_m_w_data), .m_r_data(a_m_r_data)
    );

    always @(posedge clk) begin
        a_mp[0] <= a_m_r_en ? mem_f(a_m_r_addr) : 32'h0;
        for (int k = 1; k < 3; k++) a_mp[k] <= a_mp[k-1];
    end
    assign a_m_r_data = a_mp[2];

    // ---------------- instance B: 3 ports, RD_LAT=2, fixed priority
    logic [2:0]  b_r_en, b_w_en, b_r_gnt, b_w_gnt, b_p_r_valid;
    logic [95:0] b_r_addr, b_w_addr, b_w_data;
    logic [31:0] b_p_r_data, b_m_r_addr, b_m_w_addr, b_m_w_data, b_m_r_data;
    logic        b_m_r_en, b_m_w_en;
    logic [31:0] b_mp [2];

    mem_arbiter #(
        .N_PORTS(3), .ADDR_W(32), .DATA_W(32), .RD_LAT(2), .PRIO_MODE(1)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .p_r_en(b_r_en), .p_r_addr(b_r_addr), .p_r_gnt(b_r_gnt),
        .p_r_valid(b_p_r_valid), .p_r_data(b_p_r_data),
        .p_w_en(b_w_en), .p_w_addr(b_w_addr), .p_w_data(b_w_data), .p_w_gnt(b_w_gnt),
        .m_r_en(b_m_r_en), .m_r_addr(b_m_r_addr), .m_w_en(b_m_w_en),
        .m_w_addr(b_m_w_addr), .m_w_data(b_m_w_data), .m_r_data(b_m_r_data)
    );

    always @(posedge clk) begin
        b_mp[0] <= b_m_r_en ? mem_f(b_m_r_addr) : 32'h0;
        b_mp[1] <= b_mp[0];
    end
    assign b_m_r_data = b_mp[1];

    // ---------------- stimulus tasks: drive one cycle, push expectations
    task automatic a_vec(input logic [3:0] r_en, input logic [3:0] w_en,
                         input logic [3:0] e_r, input logic [3:0] e_w, input bit ret);
        gexp_t g;
        rexp_t q;
        a_r_en = r_en;
        a_w_en = w_en;
        g.r_gnt = e_r; g.w_gnt = e_w;
        g.r_addr = '0; g.w_addr = '0; g.w_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (e_r[i]) g.r_addr = a_r_addr[i*32 +: 32];
            if (e_w[i]) begin
                g.w_addr = a_w_addr[i*32 +: 32];
                g.w_data = a_w_data[i*32 +: 32];
            end
        end
        a_gq.push_back(g);
        if (ret && e_r != 4'b0) begin
            q.vld = e_r; q.data = mem_f(g.r_addr); q.due = cyc + 3;
            a_rq.push_back(q);
        end
        @(posedge clk); #1;
    endtask

    task automatic b_vec(input logic [2:0] r_en, input logic [2:0] w_en,
                         input logic [2:0] e_r, input logic [2:0] e_w, input bit ret);
        gexp_t g;
        rexp_t q;
        b_r_en = r_en;
        b_w_en = w_en;
        g.r_gnt = {1'b0, e_r}; g.w_gnt = {1'b0, e_w};
        g.r_addr = '0; g.w_addr = '0; g.w_data = '0;
        for (int i = 0; i < 3; i++) begin
            if (e_r[i]) g.r_addr = b_r_addr[i*32 +: 32];
            if (e_w[i]) begin
                g.w_addr = b_w_addr[i*32 +: 32];
                g.w_data = b_w_data[i*32 +: 32];
            end
        end
        b_gq.push_back(g);
        if (ret && e_r != 3'b0) begin
            q.vld = {1'b0, e_r}; q.data = mem_f(g.r_addr); q.due = cyc + 2;
            b_rq.push_back(q);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- monitors
    always @(negedge clk) begin
        if (a_gq.size() > 0) begin
            a_ge = a_gq.pop_front();
            check("a_r_gnt", a_r_gnt, a_ge.r_gnt);
            check("a_w_gnt", a_w_gnt, a_ge.w_gnt);
            check("a_m_r_en", a_m_r_en, |a_ge.r_gnt);
            check("a_m_w_en", a_m_w_en, |a_ge.w_gnt);
            if (a_ge.r_gnt != 4'b0) check("a_m_r_addr", a_m_r_addr, a_ge.r_addr);
            if (a_ge.w_gnt != 4'b0) begin
                check("a_m_w_addr", a_m_w_addr, a_ge.w_addr);
                check("a_m_w_data", a_m_w_data, a_ge.w_data);
            end
        end
        if (a_rq.size() > 0 && a_rq[0].due == cyc) begin
            a_re = a_rq.pop_front();
            check("a_r_valid", a_p_r_valid, a_re.vld);
            check("a_r_data", a_p_r_data, a_re.data);
        end else begin
            check("a_r_valid_idle", a_p_r_valid, 4'b0);
        end
    end

    always @(negedge clk) begin
        if (b_gq.size() > 0) begin
            b_ge = b_gq.pop_front();
            check("b_r_gnt", b_r_gnt, b_ge.r_gnt);
            check("b_w_gnt", b_w_gnt, b_ge.w_gnt);
            check("b_m_r_en", b_m_r_en, |b_ge.r_gnt);
            check("b_m_w_en", b_m_w_en, |b_ge.w_gnt);
            if (b_ge.r_gnt != 4'b0) check("b_m_r_addr", b_m_r_addr, b_ge.r_addr);
            if (b_ge.w_gnt != 4'b0) begin
                check("b_m_w_addr", b_m_w_addr, b_ge.w_addr);
                check("b_m_w_data", b_m_w_data, b_ge.w_data);
            end
        end
        if (b_rq.size() > 0 && b_rq[0].due == cyc) begin
            b_re = b_rq.pop_front();
            check("b_r_valid", b_p_r_valid, b_re.vld);
            check("b_r_data", b_p_r_data, b_re.data);
        end else begin
            check("b_r_valid_idle", b_p_r_valid, 3'b0);
        end
    end

    // ---------------- directed sequence
    initial begin
        a_r_en = '0; a_w_en = '0; b_r_en = '0; b_w_en = '0;
        a_r_addr = {32'h30, 32'h20, 32'h10, 32'h08};
        a_w_addr = {32'h20C, 32'h208, 32'h4, 32'h200};
        a_w_data = {32'h3333, 32'h2222, 32'hDEAD, 32'h1111};
        b_r_addr = {32'h58, 32'h54, 32'h50};
        b_w_addr = {32'h48, 32'h44, 32'h40};
        b_w_data = {32'hC7, 32'hB6, 32'hA5};
        repeat (2) @(posedge clk);
        #1;

        // requests during reset: no grants, no memory requests, no returns
        a_vec(4'b1111, 4'b1111, 4'b0, 4'b0, 0);
        b_vec(3'b111, 3'b111, 3'b0, 3'b0, 0);
        a_vec(4'b0, 4'b0, 4'b0, 4'b0, 0);
        b_vec(3'b0, 3'b0, 3'b0, 3'b0, 0);
        rst = 1'b0;

        // ports 0 and 1 read continuously from the first cycle out of reset
        a_vec(4'b0011, 4'b0, 4'b0001, 4'b0, 1);
        a_vec(4'b0011, 4'b0, 4'b0010, 4'b0, 1);
        a_vec(4'b0011, 4'b0, 4'b0001, 4'b0, 1);
        a_vec(4'b0011, 4'b0, 4'b0010, 4'b0, 1);
        repeat (4) a_vec(4'b0, 4'b0, 4'b0, 4'b0, 0);

        // ports 1 and 3 read (pointer at 2): 3 wins, 1 holds and wins next
        a_vec(4'b1010, 4'b0, 4'b1000, 4'b0, 1);
        a_vec(4'b0010, 4'b0, 4'b0010, 4'b0, 1);
        // single requester: granted every cycle
        repeat (3) a_vec(4'b0100, 4'b0, 4'b0100, 4'b0, 1);
        // concurrent read (port 0, 0x8) and write (port 1, 0xDEAD to 0x4)
        a_vec(4'b0001, 4'b0010, 4'b0001, 4'b0010, 1);
        repeat (4) a_vec(4'b0, 4'b0, 4'b0, 4'b0, 0);

        // write pointer wrap: port 3 alone, then all four
        a_vec(4'b0, 4'b1000, 4'b0, 4'b1000, 0);
        a_vec(4'b0, 4'b1111, 4'b0, 4'b0001, 0);
        a_vec(4'b0, 4'b1111, 4'b0, 4'b0010, 0);
        a_vec(4'b0, 4'b1111, 4'b0, 4'b0100, 0);
        a_vec(4'b0, 4'b1111, 4'b0, 4'b1000, 0);
        a_vec(4'b0, 4'b1111, 4'b0, 4'b0001, 0);

        // read in flight killed by reset; both pointers back to 0 afterwards
        a_vec(4'b0100, 4'b0, 4'b0100, 4'b0, 0);
        rst = 1'b1;
        a_vec(4'b0, 4'b0, 4'b0, 4'b0, 0);
        rst = 1'b0;
        a_vec(4'b1001, 4'b1001, 4'b0001, 4'b0001, 1);
        repeat (5) a_vec(4'b0, 4'b0, 4'b0, 4'b0, 0);

        // fixed priority: port 0 monopolises writes, port 1 beats port 2 on reads
        b_vec(3'b110, 3'b111, 3'b010, 3'b001, 1);
        b_vec(3'b110, 3'b111, 3'b010, 3'b001, 1);
        b_vec(3'b100, 3'b111, 3'b100, 3'b001, 1);
        b_vec(3'b0, 3'b110, 3'b0, 3'b010, 0);
        b_vec(3'b0, 3'b100, 3'b0, 3'b100, 0);
        repeat (4) b_vec(3'b0, 3'b0, 3'b0, 3'b0, 0);

        check("a_returns_outstanding", 64'(a_rq.size()), 64'd0);
        check("b_returns_outstanding", 64'(b_rq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N_PORTS, default 2, number of requester ports (2..8).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width.
REQ-004 Parameter RD_LAT, default 1, memory read latency in cycles (1..4).
REQ-005 Parameter PRIO_MODE, default 0; 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 p_r_en  in  N_PORTS  per-port read request.
REQ-009 p_r_addr  in  N_PORTS*ADDR_W  per-port read address, port i at bits [i*ADDR_W +: ADDR_W].
REQ-010 p_r_gnt  out  N_PORTS  read request accepted this cycle, one-hot or zero.
REQ-011 p_r_valid  out  N_PORTS  read data valid for the port, one-hot or zero.
REQ-012 p_r_data  out  DATA_W  read data, broadcast to all ports, qualified by p_r_valid.
REQ-013 p_w_en  in  N_PORTS  per-port write request.
REQ-014 p_w_addr  in  N_PORTS*ADDR_W  per-port write address, packed as p_r_addr.
REQ-015 p_w_data  in  N_PORTS*DATA_W  per-port write data, packed likewise.
REQ-016 p_w_gnt  out  N_PORTS  write accepted this cycle, one-hot or zero.
REQ-017 m_r_en, m_r_addr[ADDR_W], m_w_en, m_w_addr[ADDR_W], m_w_data[DATA_W]  out  memory-side request.
REQ-018 m_r_data  in  DATA_W  memory read data, valid RD_LAT cycles after m_r_en.

Function
REQ-019 Read and write channels SHALL be arbitrated independently; one read and one write may issue in the same cycle.
REQ-020 Grants SHALL be combinational from current requests and registered arbiter state; a granted request drives the m_* signals in the same cycle.
REQ-021 A requester SHALL hold enable, address and data stable until granted; the arbiter does not latch ungranted requests.
REQ-022 Round-robin: search starts at pointer ptr; after a grant to port k, ptr SHALL become (k+1) mod N_PORTS at the next edge; no grant leaves ptr unchanged.
REQ-023 Fixed priority: the lowest-indexed requesting port SHALL win; pointers are ignored.
REQ-024 With no requests, m_r_en and m_w_en SHALL be 0 and all grants 0.
REQ-025 Read return: the granted port index SHALL enter an RD_LAT-deep shift pipeline; p_r_valid[idx] SHALL assert for exactly one cycle RD_LAT cycles after the grant, with p_r_data = m_r_data.
REQ-026 Back-to-back reads SHALL sustain one per cycle; returns are delivered in issue order.
REQ-027 Same-address read and write in the same cycle SHALL be passed to memory unchanged; ordering is the memory's read-during-write behaviour.
REQ-028 Round-robin pointers SHALL wrap from N_PORTS-1 to 0.
REQ-029 With a single requester, it SHALL be granted every cycle it requests (no bubbles).

Reset
REQ-030 While rst=1, all grants, p_r_valid, m_r_en, m_w_en SHALL be 0.
REQ-031 Reset SHALL set both pointers to 0 and clear the read-return pipeline.
REQ-032 Reads issued before or during reset SHALL never produce p_r_valid.
REQ-033 The first request after rst deasserts SHALL be arbitrated in that same cycle.

Structure
REQ-034 PRIO_MODE encodings and the packed-slice index helper SHALL live in the shared package core_pkg.
REQ-035 One sub-module rr_arbiter (request vector in, one-hot grant out, own pointer) SHALL be instantiated twice, for read and for write.

Verification
REQ-036 N=2, RD_LAT=1: port0 and port1 both read continuously for 4 cycles -> grants alternate 0,1,0,1; p_r_valid follows each grant by 1 cycle with matching data.
REQ-037 N=4, RD_LAT=3: ports 1 and 3 read, addresses 0x10/0x30 -> p_r_valid[1] then p_r_valid[3], each exactly 3 cycles after its grant, data from 0x10 then 0x30.
REQ-038 PRIO_MODE=1, N=3: all ports request writes for 3 cycles -> p_w_gnt=001 each cycle; ports 1 and 2 starved, data 0xA5 written thrice to port0 address.
REQ-039 Port0 reads 0x8 while port1 writes 0xDEAD to 0x4 same cycle -> both granted, m_r_en and m_w_en both 1.
REQ-040 RD_LAT=2: grant read, assert rst next cycle for 1 cycle -> no p_r_valid ever; ptr=0 after reset.
REQ-041 N=3 round-robin: only port 2 requests, then all three -> port 2, then 0,1,2 (pointer wrap).
